// File: rtl/runner_arbiter_pkg.sv
// Shared types and constants for the runner_arbiter packing controller.
package runner_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int WORDS_OUT_W = 16;

    // Source index width; a single requester still gets a one-bit field.
    function automatic int src_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/runner_arbiter_if.sv
// Requester-side beat handshakes and the assembled-word output handshake.
interface runner_arbiter_if
    import runner_arbiter_pkg::*;
#(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 8,
    parameter int NUM_REQ   = 4
);
    localparam int SRC_W = src_width(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*WIDTH_IN-1:0] req_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH_OUT-1:0]        out_data;
    logic [SRC_W-1:0]            out_src;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/runner_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, wrapping.
module rr_arbiter
    import runner_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int SRC_W   = src_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic [SRC_W-1:0]   grant,
    output logic               any_req
);

    // Scan from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise an
        // empty request vector would leave grant unassigned and infer a latch.
        grant   = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx]) begin
                grant   = SRC_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/runner_arbiter.sv
// Grants one narrow requester at a time in round-robin order, packs its
// RATIO beats into one wide word and presents it tagged with the source index.
module runner_arbiter
    import runner_arbiter_pkg::*;
#(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    runner_arbiter_if.slave        bus,
    output logic                   busy,
    output logic [WORDS_OUT_W-1:0] words_out
);

    localparam int RATIO = WIDTH_OUT / WIDTH_IN;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int SRC_W = src_width(NUM_REQ);

    if (NUM_REQ < 1 || WIDTH_OUT < WIDTH_IN || (WIDTH_OUT % WIDTH_IN) != 0) begin : g_param_check
        $error("runner_arbiter: WIDTH_OUT must be a non-zero multiple of WIDTH_IN and NUM_REQ must be >= 1");
    end

    state_t                 state_q;
    state_t                 state_d;
    logic [SRC_W-1:0]       grant_q;
    logic [SRC_W-1:0]       last_grant_q;
    logic [SRC_W-1:0]       pick;
    logic [SRC_W-1:0]       pick_ptr;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [WIDTH_OUT-1:0]   data_q;
    logic [WORDS_OUT_W-1:0] words_q;
    logic [WIDTH_IN-1:0]    beat;
    logic                   beat_valid;
    logic                   any_req;
    logic                   beat_fire;
    logic                   last_beat;
    logic                   out_fire;

    // In EMIT the pointer must already point at the word being handed off.
    assign pick_ptr = (state_q == EMIT) ? grant_q : last_grant_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (pick_ptr),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_comb begin
        beat       = '0;
        beat_valid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_q == SRC_W'(r)) begin
                beat       = bus.req_data[r*WIDTH_IN +: WIDTH_IN];
                beat_valid = bus.req_valid[r];
            end
        end
    end

    assign beat_fire = (state_q == COLLECT) && beat_valid;
    assign last_beat = (beat_cnt_q == CNT_W'(RATIO - 1));
    assign out_fire  = (state_q == EMIT) && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = COLLECT;
            COLLECT: if (beat_fire && last_beat) state_d = EMIT;
            EMIT:    if (out_fire) state_d = any_req ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the assembly register is reset even though it is only
        // qualified by out_valid, because out_data must read zero after reset.
        if (!reset_n) begin
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            data_q       <= '0;
            words_q      <= '0;
        end else begin
            if ((state_q == IDLE || out_fire) && any_req) begin
                grant_q    <= pick;
                beat_cnt_q <= '0;
            end
            if (beat_fire) begin
                for (int s = 0; s < RATIO; s++) begin
                    if (beat_cnt_q == CNT_W'(s)) data_q[s*WIDTH_IN +: WIDTH_IN] <= beat;
                end
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
            end
            if (out_fire) begin
                words_q      <= words_q + WORDS_OUT_W'(1);
                last_grant_q <= grant_q;
            end
        end
    end

    // Outputs depend on registered state only; req_valid never reaches req_ready.
    always_comb begin
        bus.req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (state_q == COLLECT && grant_q == SRC_W'(r)) bus.req_ready[r] = 1'b1;
        end
        bus.out_valid = (state_q == EMIT);
        bus.out_data  = data_q;
        bus.out_src   = grant_q;
        busy          = (state_q != IDLE);
    end

    assign words_out = words_q;

endmodule

// File: tb/tb_runner_arbiter.sv
// Directed bench for runner_arbiter: queue-driven requesters, a transaction-level
// reference model compared every cycle, and literal checks on key cycles.
module tb_runner_arbiter;

    localparam int WIDTH_IN  = 4;
    localparam int WIDTH_OUT = 8;
    localparam int NUM_REQ   = 4;
    localparam int RATIO     = WIDTH_OUT / WIDTH_IN;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic [15:0] words_out;

    runner_arbiter_if #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .NUM_REQ(NUM_REQ)) bus ();

    runner_arbiter #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .NUM_REQ   (NUM_REQ)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Requester sources: each holds a queue of beats and presents the head.
    logic [WIDTH_IN-1:0] src_q [NUM_REQ][$];
    bit                  stall [NUM_REQ];
    bit                  hs_pend [NUM_REQ];

    always @(negedge clk) begin
        for (int r = 0; r < NUM_REQ; r++) hs_pend[r] = bus.req_valid[r] & bus.req_ready[r];
    end

    always @(posedge clk) begin
        logic [NUM_REQ-1:0]          v;
        logic [NUM_REQ*WIDTH_IN-1:0] d;
        #2;
        v = '0;
        d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (hs_pend[r] && src_q[r].size() > 0) src_q[r].delete(0);
            hs_pend[r] = 1'b0;
            if (src_q[r].size() > 0 && !stall[r]) begin
                v[r] = 1'b1;
                d[r*WIDTH_IN +: WIDTH_IN] = src_q[r][0];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
    end

    // Reference model: who owns the datapath, which beats it has collected,
    // and whether a finished word is waiting for the consumer.
    bit                   m_collecting;
    bit                   m_word_ready;
    int                   m_owner;
    int                   m_src;
    int                   m_ptr;
    logic [WIDTH_IN-1:0]  m_beats [$];
    logic [WIDTH_OUT-1:0] m_word;
    logic [15:0]          m_count;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (ptr + k) % NUM_REQ;
            if (v[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int p;
        if (!reset_n) begin
            m_collecting = 1'b0;
            m_word_ready = 1'b0;
            m_owner      = 0;
            m_src        = 0;
            m_ptr        = NUM_REQ - 1;
            m_beats.delete();
            m_word       = '0;
            m_count      = '0;
        end else if (m_word_ready) begin
            if (bus.out_ready) begin
                m_count++;
                m_ptr        = m_src;
                m_word_ready = 1'b0;
                p = rr_pick(bus.req_valid, m_ptr);
                if (p >= 0) begin
                    m_collecting = 1'b1;
                    m_owner      = p;
                    m_beats.delete();
                end
            end
        end else if (m_collecting) begin
            if (bus.req_valid[m_owner] === 1'b1) begin
                m_beats.push_back(bus.req_data[m_owner*WIDTH_IN +: WIDTH_IN]);
                if (m_beats.size() == RATIO) begin
                    m_word = '0;
                    foreach (m_beats[b]) m_word = m_word | (WIDTH_OUT'(m_beats[b]) << (b * WIDTH_IN));
                    m_src        = m_owner;
                    m_word_ready = 1'b1;
                    m_collecting = 1'b0;
                end
            end
        end else begin
            p = rr_pick(bus.req_valid, m_ptr);
            if (p >= 0) begin
                m_collecting = 1'b1;
                m_owner      = p;
                m_beats.delete();
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        exp_ready = m_collecting ? (NUM_REQ'(1) << m_owner) : '0;
        check("cyc_req_ready", bus.req_ready, exp_ready);
        check("cyc_out_valid", bus.out_valid, m_word_ready);
        check("cyc_busy", busy, m_collecting | m_word_ready);
        check("cyc_words_out", words_out, m_count);
        if (m_word_ready) begin
            check("cyc_out_data", bus.out_data, m_word);
            check("cyc_out_src", bus.out_src, m_src);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NUM_REQ; r++) n += src_q[r].size();
        return n;
    endfunction

    task automatic wait_out(input int limit);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("wait_out_valid", bus.out_valid, 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy !== 1'b0 || pending() != 0) && n < limit) begin
            tick();
            n++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    task automatic clear_sources();
        for (int r = 0; r < NUM_REQ; r++) begin
            src_q[r].delete();
            stall[r] = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.out_ready = 1'b1;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_src", bus.out_src, 0);
        check("rst_busy", busy, 0);
        check("rst_words_out", words_out, 0);
        reset_n = 1'b1;

        // Single burst from requester 1: beats A then 5 give 0x5A three cycles on.
        src_q[1].push_back(4'hA);
        src_q[1].push_back(4'h5);
        tick();
        check("t1_ready_e0", bus.req_ready, 4'b0010);
        check("t1_valid_e0", bus.out_valid, 0);
        tick();
        check("t1_valid_e1", bus.out_valid, 0);
        tick();
        check("t1_valid_e2", bus.out_valid, 1);
        check("t1_data", bus.out_data, 8'h5A);
        check("t1_src", bus.out_src, 1);
        tick();
        check("t1_words", words_out, 1);
        check("t1_valid_after", bus.out_valid, 0);
        wait_idle(20);

        // Requesters 0 and 2 from a fresh reset: 0 first, 2 waits for the handshake.
        #2 reset_n = 1'b0;
        #1 clear_sources();
        reset_n = 1'b1;
        tick();
        for (int r = 0; r < NUM_REQ; r += 2) begin
            src_q[r].push_back(4'h1);
            src_q[r].push_back(4'h2);
        end
        tick();
        check("t2_ready_e0", bus.req_ready, 4'b0001);
        tick();
        check("t2_ready_e1", bus.req_ready, 4'b0001);
        tick();
        check("t2_ready_e2", bus.req_ready, 4'b0000);
        check("t2_src_a", bus.out_src, 0);
        check("t2_data_a", bus.out_data, 8'h21);
        tick();
        check("t2_ready_e3", bus.req_ready, 4'b0100);
        check("t2_words_a", words_out, 1);
        wait_out(10);
        check("t2_src_b", bus.out_src, 2);
        check("t2_data_b", bus.out_data, 8'h21);
        tick();
        check("t2_words_b", words_out, 2);
        wait_idle(20);

        // Requester 3 stalls after beat 0 while requester 0 waits; no preemption.
        src_q[3].push_back(4'h9);
        src_q[3].push_back(4'hC);
        src_q[0].push_back(4'h6);
        src_q[0].push_back(4'h7);
        tick();
        check("t3_ready_e0", bus.req_ready, 4'b1000);
        tick();
        stall[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_ready", bus.req_ready, 4'b1000);
            check("t3_stall_valid", bus.out_valid, 0);
        end
        stall[3] = 1'b0;
        tick();
        check("t3_valid", bus.out_valid, 1);
        check("t3_data", bus.out_data, 8'hC9);
        check("t3_src", bus.out_src, 3);
        tick();
        check("t3_next_ready", bus.req_ready, 4'b0001);
        check("t3_words", words_out, 3);
        wait_out(10);
        check("t3_data_0", bus.out_data, 8'h76);
        check("t3_src_0", bus.out_src, 0);
        wait_idle(20);

        // Consumer back-pressure for 10 cycles, then straight into the next burst.
        bus.out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) src_q[1].push_back(4'(b));
        wait_out(10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", bus.out_valid, 1);
            check("t4_hold_data", bus.out_data, 8'h21);
        end
        bus.out_ready = 1'b1;
        tick();
        check("t4_words", words_out, 5);
        check("t4_no_idle_busy", busy, 1);
        check("t4_no_idle_ready", bus.req_ready, 4'b0010);
        wait_out(10);
        check("t4_data_2", bus.out_data, 8'h43);
        check("t4_src_2", bus.out_src, 1);
        wait_idle(20);

        // Asynchronous reset between beat 0 and beat 1 discards the partial word.
        src_q[2].push_back(4'h3);
        src_q[2].push_back(4'h4);
        tick();
        check("t5_ready_e0", bus.req_ready, 4'b0100);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_ready", bus.req_ready, 0);
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_data", bus.out_data, 0);
        check("t5_rst_src", bus.out_src, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_words", words_out, 0);
        clear_sources();
        reset_n = 1'b1;
        src_q[2].push_back(4'h7);
        src_q[2].push_back(4'h8);
        wait_out(10);
        check("t5_data", bus.out_data, 8'h87);
        check("t5_src", bus.out_src, 2);
        tick();
        check("t5_words", words_out, 1);
        wait_idle(20);

        // Counter wrap: preload to 0xFFFE, then two more handshakes.
        force dut.words_q = 16'hFFFE;
        m_count = 16'hFFFE;
        #1 release dut.words_q;
        tick();
        check("t6_preload", words_out, 16'hFFFE);
        src_q[0].push_back(4'hF);
        src_q[0].push_back(4'hE);
        wait_out(10);
        check("t6_data", bus.out_data, 8'hEF);
        tick();
        check("t6_words_ffff", words_out, 16'hFFFF);
        src_q[0].push_back(4'h1);
        src_q[0].push_back(4'h0);
        wait_out(10);
        tick();
        check("t6_words_wrap", words_out, 16'h0000);
        wait_idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
